// File: rtl/vector_fetch_engine.sv
// vector_fetch_engine: pops byte addresses from the address FIFO, reads the
// matching 256-bit vector from the vector BRAM and pushes it into the vector
// FIFO. Issue is credit-throttled against the FIFO occupancy plus the fetches
// still travelling through the BRAM pipeline, so the vector FIFO never overruns.
module vector_fetch_engine #(
    parameter int DATA_WIDTH      = 256,
    parameter int BRAM_ADDR_WIDTH = 16,
    parameter int ADDR_SHIFT      = 5,
    parameter int BRAM_LATENCY    = 2,
    parameter int VCTR_FIFO_DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run_program,
    input  logic                       end_program,
    input  logic [31:0]                addr_fifo_dout,
    input  logic                       addr_fifo_empty,
    output logic                       addr_fifo_rd,
    output logic                       bram_en,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0]      bram_rdata,
    input  logic [15:0]                words_in_vctr_fifo,
    input  logic                       vector_fifo_full,
    output logic [DATA_WIDTH-1:0]      vctr_fifo_din,
    output logic                       vctr_fifo_wr,
    output logic [31:0]                fetch_cnt,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun_err
);

    // Holds 0..BRAM_LATENCY+1 outstanding fetches.
    localparam int INFLIGHT_WIDTH = $clog2(BRAM_LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic                      run_prev_reg;
    logic                      run_rise;
    logic                      start;
    logic                      issue;
    logic                      done_next;
    logic                      done_reg;
    logic                      credit_ok;
    logic [31:0]               credit_sum;
    logic                      rd_d1_reg;
    logic [BRAM_LATENCY-1:0]   rd_vld_reg;
    logic [BRAM_LATENCY:0]     vld_chain;
    logic [INFLIGHT_WIDTH-1:0] inflight_reg;
    logic [INFLIGHT_WIDTH-1:0] inflight_next;
    logic [31:0]               fetch_cnt_reg;
    logic                      overrun_reg;
    logic                      addr_unused;

    // Only the vector-index slice of the byte address is consumed.
    assign addr_unused = ^addr_fifo_dout;

    // Registered edge detect so a level held across a program does not restart it.
    assign run_rise = run_program & ~run_prev_reg;

    // Outstanding fetches count against free FIFO space.
    assign credit_sum = 32'(words_in_vctr_fifo) + 32'(inflight_reg);
    assign credit_ok  = credit_sum < 32'(VCTR_FIFO_DEPTH);

    // State register, edge-detect history and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            run_prev_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            run_prev_reg <= run_program;
            done_reg     <= done_next;
        end
    end

    // Next-state and issue decision; end_program beats both start and issue.
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        start      = 1'b0;
        done_next  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (run_rise && !end_program) begin
                    state_next = FETCH;
                    start      = 1'b1;
                end
            end
            FETCH: begin
                if (end_program) begin
                    state_next = DRAIN;
                end else begin
                    issue = !addr_fifo_empty && credit_ok;
                end
            end
            DRAIN: begin
                if (inflight_reg == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Valid chain: bit 0 is the BRAM enable cycle, bit gi+1 is gi+1 cycles later.
    assign vld_chain[0] = rd_d1_reg;
    generate
        for (genvar gi = 0; gi < BRAM_LATENCY; gi++) begin : g_vld_chain
            assign vld_chain[gi+1] = rd_vld_reg[gi];
        end
    endgenerate

    // Issue pipeline: address-FIFO read, then BRAM enable, then BRAM_LATENCY stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_d1_reg  <= 1'b0;
            rd_vld_reg <= '0;
        end else begin
            rd_d1_reg  <= issue;
            rd_vld_reg <= vld_chain[BRAM_LATENCY-1:0];
        end
    end

    // Outstanding-fetch counter: +1 on read strobe, -1 on FIFO write.
    always_comb begin
        inflight_next = inflight_reg;
        if (issue && !vctr_fifo_wr) begin
            inflight_next = inflight_reg + 1'b1;
        end else if (!issue && vctr_fifo_wr) begin
            inflight_next = inflight_reg - 1'b1;
        end
    end

    // Outstanding-fetch register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
        end
    end

    // Written-vector counter (cleared on program start) and sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_reg <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            if (start) begin
                fetch_cnt_reg <= '0;
            end else if (vctr_fifo_wr) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (vctr_fifo_wr && vector_fifo_full) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Address FIFO data arrives the cycle after the read strobe and goes straight
    // to the BRAM; BRAM data goes straight to the FIFO when it becomes valid.
    assign addr_fifo_rd  = issue;
    assign bram_en       = rd_d1_reg;
    assign bram_addr     = rd_d1_reg ? addr_fifo_dout[ADDR_SHIFT +: BRAM_ADDR_WIDTH] : '0;
    assign vctr_fifo_wr  = rd_vld_reg[BRAM_LATENCY-1];
    assign vctr_fifo_din = vctr_fifo_wr ? bram_rdata : '0;
    assign fetch_cnt     = fetch_cnt_reg;
    assign busy          = (state_reg != IDLE);
    assign done          = done_reg;
    assign overrun_err   = overrun_reg;

endmodule
